// File: rtl/prog_divider_bank_pkg.sv
// Shared constants and helpers for the programmable clock-divider bank.
// Holds the reset divisor default, the minimum half-period and the channel-index width function.
package prog_divider_bank_pkg;

  localparam int DEF_DIV_DEFAULT = 1000;
  localparam int MIN_DIV         = 1;

  // A single-channel bank still needs a 1-bit select port.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/prog_divider_chan.sv
// One divider channel: 50% duty output toggling every cur_div enabled cycles, tick on each rise.
// Outputs are registered; new divisors queue as pending and apply only at a half-period boundary or sync.
module prog_divider_chan
  import prog_divider_bank_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] RST_DIV = (DEF_DIV == 0) ? MIN_VAL : CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur_div;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] wr_div;
  logic             pend_valid;
  logic             at_bound;

  assign wr_div   = (wr_val == '0) ? MIN_VAL : wr_val;
  // cur_div only changes when cnt is 0, so >= never fires early; it just keeps cnt bounded.
  assign at_bound = (cnt >= cur_div - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      cur_div    <= RST_DIV;
      pend_div   <= RST_DIV;
      pend_valid <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        if (pend_valid) begin
          cur_div    <= pend_div;
          pend_valid <= 1'b0;
        end
      end else if (en) begin
        if (at_bound) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          if (pend_valid) begin
            cur_div    <= pend_div;
            pend_valid <= 1'b0;
          end
        end else begin
          cnt <= cnt + ONE;
        end
      end
      // A write landing with a boundary or sync stays pending for the next one.
      if (we) begin
        pend_div   <= wr_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_divider_bank.sv
// Bank of N_CH independent programmable clock dividers sharing one divisor write port and a sync pulse.
// Outputs registered (one cycle after the controlling edge); no backpressure, writes always accepted.
module prog_divider_bank
  import prog_divider_bank_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic                      I_CLK,
  input  logic                      rst,
  input  logic [N_CH-1:0]           en,
  input  logic                      div_we,
  input  logic [ch_idx_w(N_CH)-1:0] div_ch,
  input  logic [CNT_W-1:0]          div_val,
  input  logic                      sync_all,
  output logic [N_CH-1:0]           O_CLK,
  output logic [N_CH-1:0]           O_TICK
);

  localparam int CH_W = ch_idx_w(N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic we_i;

    // Select values with no matching channel simply decode to nothing.
    assign we_i = div_we && (div_ch == CH_W'(i));

    prog_divider_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk    (I_CLK),
      .rst    (rst),
      .en     (en[i]),
      .we     (we_i),
      .wr_val (div_val),
      .sync   (sync_all),
      .clk_out(O_CLK[i]),
      .tick   (O_TICK[i])
    );
  end

endmodule

// File: tb/tb_prog_divider_bank.sv
// Directed bench for prog_divider_bank: 4 channels, 16-bit counters, reset divisor 4.
module tb_prog_divider_bank;

  logic        I_CLK = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        div_we;
  logic [1:0]  div_ch;
  logic [15:0] div_val;
  logic        sync_all;
  logic [3:0]  O_CLK;
  logic [3:0]  O_TICK;

  int checks = 0;
  int errors = 0;

  prog_divider_bank #(
    .N_CH   (4),
    .CNT_W  (16),
    .DEF_DIV(4)
  ) dut (
    .I_CLK   (I_CLK),
    .rst     (rst),
    .en      (en),
    .div_we  (div_we),
    .div_ch  (div_ch),
    .div_val (div_val),
    .sync_all(sync_all),
    .O_CLK   (O_CLK),
    .O_TICK  (O_TICK)
  );

  always #5 I_CLK = ~I_CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic apply_reset();
    rst = 1'b1; en = '0; div_we = 1'b0; div_ch = '0; div_val = '0; sync_all = 1'b0;
    repeat (2) @(negedge I_CLK);
    rst = 1'b0;
  endtask

  task automatic write_div(input logic [1:0] ch, input logic [15:0] val);
    div_we = 1'b1; div_ch = ch; div_val = val;
    @(negedge I_CLK);
    div_we = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_all = 1'b1;
    @(negedge I_CLK);
    sync_all = 1'b0;
  endtask

  // Cycles until O_CLK[ch] reads lvl; -1 if it never does within the budget.
  task automatic count_until(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      @(negedge I_CLK);
      n++;
    end while (O_CLK[ch] !== lvl && n < 100);
    if (O_CLK[ch] !== lvl) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'b1111; div_we = 1'b0; div_ch = '0; div_val = '0; sync_all = 1'b0;
    repeat (3) @(negedge I_CLK);
    checks++; if (O_CLK !== 4'b0000) begin errors++; $display("FAIL reset_clk got %b want 0000", O_CLK); end
    checks++; if (O_TICK !== 4'b0000) begin errors++; $display("FAIL reset_tick got %b want 0000", O_TICK); end
    rst = 1'b0; en = '0;
  endtask

  task automatic test_basic();
    logic [3:0] exp_clk, exp_tick;
    apply_reset();
    en = 4'b0001;
    for (int j = 1; j <= 24; j++) begin
      @(negedge I_CLK);
      exp_clk  = {3'b000, ((j / 4) % 2) == 1};
      exp_tick = {3'b000, (j % 8) == 4};
      checks++; if (O_CLK !== exp_clk) begin errors++; $display("FAIL basic_clk cyc %0d got %b want %b", j, O_CLK, exp_clk); end
      checks++; if (O_TICK !== exp_tick) begin errors++; $display("FAIL basic_tick cyc %0d got %b want %b", j, O_TICK, exp_tick); end
    end
  endtask

  task automatic test_pending_write();
    int n;
    apply_reset();
    write_div(2'd1, 16'd3);
    pulse_sync();
    en = 4'b0010;
    count_until(1, 1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL div3_rise got %0d want 3", n); end
    // Write 5 while the high phase is at cnt=1; this half-period must still be 3 long.
    @(negedge I_CLK);
    write_div(2'd1, 16'd5);
    count_until(1, 1'b0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL midphase_fall got %0d want 1", n); end
    count_until(1, 1'b1, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL div5_low got %0d want 5", n); end
    count_until(1, 1'b0, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL div5_high got %0d want 5", n); end
    // Low phase of 5 just began; write 2 on the rising boundary, then 6 right after.
    repeat (4) @(negedge I_CLK);
    write_div(2'd1, 16'd2);
    checks++; if (O_CLK[1] !== 1'b1) begin errors++; $display("FAIL bound_rise got %b want 1", O_CLK[1]); end
    write_div(2'd1, 16'd6);
    count_until(1, 1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL bound_high_rest got %0d want 4", n); end
    count_until(1, 1'b1, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL lastwin_low got %0d want 6", n); end
    count_until(1, 1'b0, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL lastwin_high got %0d want 6", n); end
  endtask

  task automatic test_div_zero();
    logic exp;
    apply_reset();
    write_div(2'd2, 16'd0);
    pulse_sync();
    en = 4'b0100;
    for (int j = 1; j <= 6; j++) begin
      @(negedge I_CLK);
      exp = ((j % 2) == 1);
      checks++; if (O_CLK !== {1'b0, exp, 2'b00}) begin errors++; $display("FAIL div0_clk cyc %0d got %b want %b", j, O_CLK, {1'b0, exp, 2'b00}); end
      checks++; if (O_TICK !== {1'b0, exp, 2'b00}) begin errors++; $display("FAIL div0_tick cyc %0d got %b want %b", j, O_TICK, {1'b0, exp, 2'b00}); end
    end
    @(negedge I_CLK);
    en = 4'b0000;
    for (int j = 1; j <= 3; j++) begin
      @(negedge I_CLK);
      checks++; if (O_CLK !== 4'b0100) begin errors++; $display("FAIL hold_clk cyc %0d got %b want 0100", j, O_CLK); end
      checks++; if (O_TICK !== 4'b0000) begin errors++; $display("FAIL hold_tick cyc %0d got %b want 0000", j, O_TICK); end
    end
  endtask

  task automatic test_sync();
    int f [3];
    apply_reset();
    en = 4'b0111;
    repeat (2) @(negedge I_CLK);
    write_div(2'd0, 16'd3);
    write_div(2'd1, 16'd5);
    write_div(2'd2, 16'd7);
    checks++; if (O_CLK !== 4'b0111) begin errors++; $display("FAIL presync_clk got %b want 0111", O_CLK); end
    pulse_sync();
    checks++; if (O_CLK !== 4'b0000) begin errors++; $display("FAIL sync_clk got %b want 0000", O_CLK); end
    checks++; if (O_TICK !== 4'b0000) begin errors++; $display("FAIL sync_tick got %b want 0000", O_TICK); end
    f = '{0, 0, 0};
    for (int j = 1; j <= 10; j++) begin
      @(negedge I_CLK);
      for (int c = 0; c < 3; c++) if (f[c] == 0 && O_CLK[c] === 1'b1) f[c] = j;
    end
    checks++; if (f[0] !== 3) begin errors++; $display("FAIL sync_rise0 got %0d want 3", f[0]); end
    checks++; if (f[1] !== 5) begin errors++; $display("FAIL sync_rise1 got %0d want 5", f[1]); end
    checks++; if (f[2] !== 7) begin errors++; $display("FAIL sync_rise2 got %0d want 7", f[2]); end
  endtask

  task automatic test_disabled_write();
    int n;
    apply_reset();
    write_div(2'd3, 16'd2);
    repeat (3) @(negedge I_CLK);
    checks++; if (O_CLK[3] !== 1'b0) begin errors++; $display("FAIL dis_hold got %b want 0", O_CLK[3]); end
    en = 4'b1000;
    count_until(3, 1'b1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL dis_first got %0d want 4", n); end
    count_until(3, 1'b0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL dis_high got %0d want 2", n); end
    count_until(3, 1'b1, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL dis_low got %0d want 2", n); end
  endtask

  task automatic test_reset_midphase();
    int n;
    apply_reset();
    write_div(2'd0, 16'd3);
    pulse_sync();
    en = 4'b0001;
    count_until(0, 1'b1, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rm_rise got %0d want 3", n); end
    write_div(2'd0, 16'd9);
    // Reset must win over a simultaneous sync and write.
    rst = 1'b1; sync_all = 1'b1; div_we = 1'b1; div_ch = 2'd0; div_val = 16'd9;
    @(negedge I_CLK);
    rst = 1'b0; sync_all = 1'b0; div_we = 1'b0;
    checks++; if (O_CLK !== 4'b0000) begin errors++; $display("FAIL rm_clk got %b want 0000", O_CLK); end
    checks++; if (O_TICK !== 4'b0000) begin errors++; $display("FAIL rm_tick got %b want 0000", O_TICK); end
    count_until(0, 1'b1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rm_first got %0d want 4", n); end
    count_until(0, 1'b0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rm_high got %0d want 4", n); end
    count_until(0, 1'b1, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rm_low got %0d want 4", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending_write();
    test_div_zero();
    test_sync();
    test_disabled_write();
    test_reset_midphase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
